muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage and the consumer of the ID-stage `FUNCT` encoding. It accepts a decoded funct code plus two 32-bit operands and runs the HI/LO-class operations: MULT/MULTU/DIV/DIVU, SPECIAL2 MADD/MADDU/MSUB/MSUBU, and MTHI/MTLO. It owns the architectural HI/LO registers and raises `busy` so the pipeline controller stalls EX until the result is written.

---
 rtl/muldiv_unit_pkg.sv | 60 ++++++
 rtl/muldiv_unit_div_core.sv | 65 ++++++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - funct codes, op decode and shared types for the HI/LO multiply/divide unit
package muldiv_unit_pkg;

    localparam int FUNCT_BUS = 6;
    localparam int DATA_BUS  = 32;

    localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MADD  = 6'h00;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MADDU = 6'h01;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MSUB  = 6'h04;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MSUBU = 6'h05;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_e;

    typedef struct packed {
        logic      is_mul;
        logic      is_div;
        logic      is_mthi;
        logic      is_mtlo;
        logic      is_signed;
        acc_mode_e acc;
    } op_dec_t;

    // SPECIAL2 reuses low funct values, so the opcode bit must qualify every match.
    function automatic op_dec_t decode_op(input logic special2, input logic [FUNCT_BUS-1:0] funct);
        op_dec_t d;
        d = '{is_mul: 1'b0, is_div: 1'b0, is_mthi: 1'b0, is_mtlo: 1'b0,
              is_signed: 1'b0, acc: ACC_NONE};
        if (!special2) begin
            case (funct)
                FUNCT_MULT:  begin d.is_mul = 1'b1; d.is_signed = 1'b1; end
                FUNCT_MULTU: d.is_mul = 1'b1;
                FUNCT_DIV:   begin d.is_div = 1'b1; d.is_signed = 1'b1; end
                FUNCT_DIVU:  d.is_div = 1'b1;
                FUNCT_MTHI:  d.is_mthi = 1'b1;
                FUNCT_MTLO:  d.is_mtlo = 1'b1;
                default:     ;
            endcase
        end else begin
            case (funct)
                FUNCT_MADD:  begin d.is_mul = 1'b1; d.is_signed = 1'b1; d.acc = ACC_ADD; end
                FUNCT_MADDU: begin d.is_mul = 1'b1; d.acc = ACC_ADD; end
                FUNCT_MSUB:  begin d.is_mul = 1'b1; d.is_signed = 1'b1; d.acc = ACC_SUB; end
                FUNCT_MSUBU: begin d.is_mul = 1'b1; d.acc = ACC_SUB; end
                default:     ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - iterative restoring radix-2 unsigned 32/32 divider
module div_core
    import muldiv_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                flush,
    input  logic [DATA_BUS-1:0] dividend,
    input  logic [DATA_BUS-1:0] divisor,
    output logic [DATA_BUS-1:0] quotient,
    output logic [DATA_BUS-1:0] remainder,
    output logic                last
);

    logic [DATA_BUS-1:0] rem_q;
    logic [DATA_BUS-1:0] quo_q;
    logic [DATA_BUS-1:0] dvs_q;
    logic [4:0]          count;
    logic                active;

    logic [DATA_BUS:0]   shifted;
    logic [DATA_BUS:0]   trial;
    logic                fits;
    logic [DATA_BUS-1:0] rem_next;
    logic [DATA_BUS-1:0] quo_next;

    // Dividend bits shift out of quo_q's top as quotient bits shift in at the bottom.
    assign shifted  = {rem_q, quo_q[DATA_BUS-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign fits     = ~trial[DATA_BUS];
    assign rem_next = fits ? trial[DATA_BUS-1:0] : shifted[DATA_BUS-1:0];
    assign quo_next = {quo_q[DATA_BUS-2:0], fits};

    // Results are the values the final iteration produces, so the parent can write them at that edge.
    assign quotient  = quo_next;
    assign remainder = rem_next;
    assign last      = active && (count == 5'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (flush) begin
            active <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            count  <= '0;
            active <= 1'b1;
        end else if (active) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count + 5'd1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 special2,
    input  logic [FUNCT_BUS-1:0] funct,
    input  logic [DATA_BUS-1:0]  opa,
    input  logic [DATA_BUS-1:0]  opb,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BUS-1:0]  hi,
    output logic [DATA_BUS-1:0]  lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]          state;
    op_dec_t             dec;

    logic [DATA_BUS-1:0] mul_a;
    logic [DATA_BUS-1:0] mul_b;
    logic                mul_signed;
    acc_mode_e           mul_acc;
    logic                div_q_neg;
    logic                div_r_neg;

    logic [DATA_BUS-1:0] abs_a;
    logic [DATA_BUS-1:0] abs_b;
    logic [DATA_BUS-1:0] div_q;
    logic [DATA_BUS-1:0] div_r;
    logic                div_last;
    logic                div_start;

    logic [63:0]         mul_a_ext;
    logic [63:0]         mul_b_ext;
    logic [63:0]         product;
    logic [63:0]         mul_result;

    assign dec       = decode_op(special2, funct);
    assign div_start = (state == S_IDLE) && start && !flush && dec.is_div;

    assign abs_a = (dec.is_signed && opa[DATA_BUS-1]) ? (~opa + 32'd1) : opa;
    assign abs_b = (dec.is_signed && opb[DATA_BUS-1]) ? (~opb + 32'd1) : opb;

    div_core u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .flush     (flush),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (div_q),
        .remainder (div_r),
        .last      (div_last)
    );

    // The 33x33 signed product truncated to 64 bits equals this 64x64 product modulo 2^64.
    assign mul_a_ext = {{32{mul_signed & mul_a[DATA_BUS-1]}}, mul_a};
    assign mul_b_ext = {{32{mul_signed & mul_b[DATA_BUS-1]}}, mul_b};
    assign product   = mul_a_ext * mul_b_ext;

    always_comb begin
        mul_result = product;
        case (mul_acc)
            ACC_ADD: mul_result = {hi, lo} + product;
            ACC_SUB: mul_result = {hi, lo} - product;
            default: mul_result = product;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = !flush && ((state == S_MUL) || ((state == S_DIV) && div_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hi         <= '0;
            lo         <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            mul_acc    <= ACC_NONE;
            div_q_neg  <= 1'b0;
            div_r_neg  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (dec.is_mul) begin
                            mul_a      <= opa;
                            mul_b      <= opb;
                            mul_signed <= dec.is_signed;
                            mul_acc    <= dec.acc;
                            state      <= S_MUL;
                        end else if (dec.is_div) begin
                            // A zero divisor must leave the all-ones quotient uncorrected.
                            div_q_neg <= dec.is_signed && (opa[DATA_BUS-1] ^ opb[DATA_BUS-1])
                                         && (opb != '0);
                            div_r_neg <= dec.is_signed && opa[DATA_BUS-1];
                            state     <= S_DIV;
                        end else if (dec.is_mthi) begin
                            hi <= opa;
                        end else if (dec.is_mtlo) begin
                            lo <= opa;
                        end
                    end
                end
                S_MUL: begin
                    {hi, lo} <= mul_result;
                    state    <= S_IDLE;
                end
                S_DIV: begin
                    if (div_last) begin
                        lo    <= div_q_neg ? (~div_q + 32'd1) : div_q;
                        hi    <= div_r_neg ? (~div_r + 32'd1) : div_r;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        special2;
    logic [5:0]  funct;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .special2 (special2),
        .funct    (funct),
        .opa      (opa),
        .opb      (opb),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural result of one instruction; returns how many cycles busy should be high.
    task automatic model_op(input logic sp2, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, output int cyc);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] hl;
        logic [63:0] q;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        hl  = {m_hi, m_lo};
        cyc = 0;
        if (!sp2) begin
            case (f)
                6'h18: begin hl = 64'(sa * sb); cyc = 1; end
                6'h19: begin hl = ua * ub; cyc = 1; end
                6'h1A, 6'h1B: begin
                    cyc = 32;
                    if (b == 32'h0) begin
                        hl = {a, 32'hFFFFFFFF};
                    end else if (f == 6'h1A) begin
                        q  = 64'(sa / sb);
                        r  = 64'(sa % sb);
                        hl = {r[31:0], q[31:0]};
                    end else begin
                        q  = ua / ub;
                        r  = ua % ub;
                        hl = {r[31:0], q[31:0]};
                    end
                end
                6'h11: hl = {a, m_lo};
                6'h13: hl = {m_hi, a};
                default: ;
            endcase
        end else begin
            case (f)
                6'h00: begin hl = hl + 64'(sa * sb); cyc = 1; end
                6'h01: begin hl = hl + ua * ub; cyc = 1; end
                6'h04: begin hl = hl - 64'(sa * sb); cyc = 1; end
                6'h05: begin hl = hl - ua * ub; cyc = 1; end
                default: ;
            endcase
        end
        m_hi = hl[63:32];
        m_lo = hl[31:0];
    endtask

    task automatic do_op(input string tag, input logic sp2, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        int exp_cyc;
        int n;
        int dn;
        model_op(sp2, f, a, b, exp_cyc);
        @(negedge clk);
        special2 = sp2;
        funct    = f;
        opa      = a;
        opb      = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n  = 0;
        dn = 0;
        while (busy && n < 64) begin
            if (done) dn++;
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_cyc));
        check({tag, "_done_pulses"}, 64'(dn), (exp_cyc > 0) ? 64'd1 : 64'd0);
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, m_hi});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, m_lo});
    endtask

    task automatic launch(input logic sp2, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        special2 = sp2;
        funct    = f;
        opa      = a;
        opb      = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        logic [5:0]  pick;
        logic        sp;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        special2 = 1'b0;
        funct    = 6'h0;
        opa      = 32'h0;
        opb      = 32'h0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        rst_n = 1'b1;

        do_op("mult_neg2x3", 1'b0, 6'h18, 32'hFFFFFFFE, 32'h3);
        check("mult_hi_const", {32'h0, hi}, 64'hFFFFFFFF);
        check("mult_lo_const", {32'h0, lo}, 64'hFFFFFFFA);
        do_op("multu_neg2x3", 1'b0, 6'h19, 32'hFFFFFFFE, 32'h3);
        check("multu_hi_const", {32'h0, hi}, 64'h2);
        do_op("div_m7_2", 1'b0, 6'h1A, 32'hFFFFFFF9, 32'h2);
        check("div_lo_const", {32'h0, lo}, 64'hFFFFFFFD);
        check("div_hi_const", {32'h0, hi}, 64'hFFFFFFFF);
        do_op("divu_100_7", 1'b0, 6'h1B, 32'd100, 32'd7);
        check("divu_lo_const", {32'h0, lo}, 64'd14);
        do_op("divu_by_zero", 1'b0, 6'h1B, 32'd5, 32'd0);
        check("divz_lo_const", {32'h0, lo}, 64'hFFFFFFFF);
        do_op("div_by_zero_neg", 1'b0, 6'h1A, 32'hFFFFFFF0, 32'd0);
        do_op("div_overflow", 1'b0, 6'h1A, 32'h80000000, 32'hFFFFFFFF);
        check("divov_lo_const", {32'h0, lo}, 64'h80000000);
        do_op("mthi_0", 1'b0, 6'h11, 32'h0, 32'h0);
        do_op("mtlo_ffff", 1'b0, 6'h13, 32'hFFFFFFFF, 32'h0);
        do_op("maddu_1x1", 1'b1, 6'h01, 32'h1, 32'h1);
        check("maddu_hi_const", {32'h0, hi}, 64'h1);
        do_op("mthi_clr", 1'b0, 6'h11, 32'h0, 32'h0);
        do_op("mtlo_clr", 1'b0, 6'h13, 32'h0, 32'h0);
        do_op("msub_1x1", 1'b1, 6'h04, 32'h1, 32'h1);
        check("msub_lo_const", {32'h0, lo}, 64'hFFFFFFFF);

        // Flush during division at cycle 10.
        launch(1'b0, 6'h1B, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_div10_busy", {63'h0, busy}, 64'h0);
        check("flush_div10_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush in the done cycle.
        launch(1'b0, 6'h1A, 32'h12345, 32'h7);
        repeat (31) @(negedge clk);
        check("pre_flush_done", {63'h0, done}, 64'h1);
        flush = 1'b1;
        #1;
        check("flush_done_forced0", {63'h0, done}, 64'h0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_busy", {63'h0, busy}, 64'h0);
        check("flush_done_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush together with MTLO start.
        @(negedge clk);
        special2 = 1'b0;
        funct    = 6'h13;
        opa      = 32'hA5A5A5A5;
        start    = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_mtlo_lo", {32'h0, lo}, {32'h0, m_lo});
        check("flush_mtlo_busy", {63'h0, busy}, 64'h0);

        do_op("ignored_addu", 1'b0, 6'h21, 32'h11111111, 32'h22222222);
        do_op("ignored_sp2_mult", 1'b1, 6'h18, 32'h3, 32'h4);

        // Second start while busy must not disturb the running divide.
        model_op(1'b0, 6'h1B, 32'd100, 32'd7, cyc);
        launch(1'b0, 6'h1B, 32'd100, 32'd7);
        n = 1;
        repeat (4) begin @(negedge clk); n++; end
        funct = 6'h11;
        opa   = 32'hDEADBEEF;
        start = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (busy && n < 64) begin @(negedge clk); n++; end
        check("busy_restart_cycles", 64'(n - 1), 64'(cyc));
        check("busy_restart_hilo", {hi, lo}, {m_hi, m_lo});

        // Reset in the middle of a divide.
        do_op("pre_rst_mthi", 1'b0, 6'h11, 32'h1234, 32'h0);
        do_op("pre_rst_mtlo", 1'b0, 6'h13, 32'h5678, 32'h0);
        launch(1'b0, 6'h1A, 32'd999, 32'd4);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        check("rst_mid_busy", {63'h0, busy}, 64'h0);
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 11))
                0:  begin sp = 1'b0; pick = 6'h18; end
                1:  begin sp = 1'b0; pick = 6'h19; end
                2:  begin sp = 1'b0; pick = 6'h1A; end
                3:  begin sp = 1'b0; pick = 6'h1B; end
                4:  begin sp = 1'b0; pick = 6'h11; end
                5:  begin sp = 1'b0; pick = 6'h13; end
                6:  begin sp = 1'b1; pick = 6'h00; end
                7:  begin sp = 1'b1; pick = 6'h01; end
                8:  begin sp = 1'b1; pick = 6'h04; end
                9:  begin sp = 1'b1; pick = 6'h05; end
                10: begin sp = 1'b0; pick = 6'h21; end
                default: begin sp = 1'b1; pick = 6'h02; end
            endcase
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 17);
                2:       rb = 32'hFFFFFFFF - $urandom_range(0, 9);
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d_f%0h_s%0d", i, pick, sp), sp, pick, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
